// File: rtl/fsm_seq_generator_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   DEF_PAT_W / DEF_LEN_W / DEF_CNT_W : default widths for pattern, length and repeat count
//   state_t                           : FSM state encodings shared with the detector blocks
package fsm_seq_generator_pkg;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_LEN_W = 4;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/fsm_seq_generator_piso_shift.sv
// Parallel-load, MSB-out shift register for the pattern transmitter.
// The loaded pattern is left-aligned so its first bit (din[dlen-1]) always sits at the MSB.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : load left-aligned din[dlen-1:0]
//   shift       : advance one bit towards the MSB
//   clr         : synchronous clear
//   din, dlen   : pattern and effective length (1..PAT_W) for load
//   load_msb_c  : first bit that a load would present (combinational from din/dlen)
//   next_bit    : bit that becomes the MSB after the next shift
module fsm_seq_generator_piso_shift
    import fsm_seq_generator_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clr,
    input  logic [PAT_W-1:0] din,
    input  logic [LEN_W-1:0] dlen,
    output logic             load_msb_c,
    output logic             next_bit
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    logic [PAT_W-1:0] sreg;
    logic [PAT_W-1:0] aligned_c;

    // Move pattern[dlen-1:0] up against the MSB so the output tap never moves
    assign aligned_c  = din << (PAT_W_L - dlen);
    assign load_msb_c = aligned_c[PAT_W-1];
    assign next_bit   = sreg[PAT_W-2];

    // Rotate rather than shift in zeros; the tail is reloaded at each pass end anyway
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else if (clr) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= aligned_c;
        end else if (shift) begin
            sreg <= {sreg[PAT_W-2:0], sreg[PAT_W-1]};
        end
    end

endmodule

// File: rtl/fsm_seq_generator.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, one bit per clock,
// repeating it repeat_n+1 times, then pulses done.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle request, accepted in IDLE or during the done cycle
//   pattern   : bits to send, pattern[len-1] first
//   len       : bits per pass; 0 or >PAT_W means PAT_W
//   repeat_n  : extra passes
//   abort     : synchronous cancel, wins over start
//   w         : serial data (0 whenever w_valid is low)
//   w_valid   : w carries a pattern bit
//   busy      : stream in progress
//   done      : one-cycle pulse after the final bit
module fsm_seq_generator
    import fsm_seq_generator_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic             w_d, w_valid_d, busy_d, done_d;

    logic             sr_load, sr_shift, sr_clr;
    logic [PAT_W-1:0] sr_din;
    logic [LEN_W-1:0] sr_len;
    logic             sr_load_msb_c, sr_next_bit;
    logic             do_load;
    logic             go_idle;
    logic [LEN_W-1:0] eff_len_c;

    // Out-of-range lengths fall back to a full-width pass
    assign eff_len_c = (len == '0 || len > PAT_W_L) ? PAT_W_L : len;

    fsm_seq_generator_piso_shift #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk        (clk),
        .rst        (rst),
        .load       (sr_load),
        .shift      (sr_shift),
        .clr        (sr_clr),
        .din        (sr_din),
        .dlen       (sr_len),
        .load_msb_c (sr_load_msb_c),
        .next_bit   (sr_next_bit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        bit_cnt_d  = bit_cnt_q;
        pass_cnt_d = pass_cnt_q;
        w_d        = 1'b0;
        w_valid_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_clr     = 1'b0;
        sr_din     = pat_q;
        sr_len     = len_q;
        do_load    = 1'b0;
        go_idle    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    do_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    go_idle = 1'b1;
                end else if (bit_cnt_q != '0) begin
                    sr_shift  = 1'b1;
                    w_d       = sr_next_bit;
                    w_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q - LEN_W'(1);
                end else if (pass_cnt_q != '0) begin
                    // Back-to-back pass: reload from the captured copy, no gap bit
                    sr_load    = 1'b1;
                    w_d        = sr_load_msb_c;
                    w_valid_d  = 1'b1;
                    busy_d     = 1'b1;
                    bit_cnt_d  = len_q - LEN_W'(1);
                    pass_cnt_d = pass_cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (start && !abort) begin
                    do_load = 1'b1;
                end else begin
                    go_idle = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        // Accept a new request: capture inputs and present the first bit next cycle
        if (do_load) begin
            state_d    = ST_SHIFT;
            pat_d      = pattern;
            len_d      = eff_len_c;
            pass_cnt_d = repeat_n;
            bit_cnt_d  = eff_len_c - LEN_W'(1);
            sr_load    = 1'b1;
            sr_din     = pattern;
            sr_len     = eff_len_c;
            w_d        = sr_load_msb_c;
            w_valid_d  = 1'b1;
            busy_d     = 1'b1;
        end

        if (go_idle) begin
            state_d    = ST_IDLE;
            pat_d      = '0;
            len_d      = '0;
            bit_cnt_d  = '0;
            pass_cnt_d = '0;
            sr_clr     = 1'b1;
        end
    end

    // Captured request, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q      <= '0;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            pass_cnt_q <= '0;
            w          <= 1'b0;
            w_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pat_q      <= pat_d;
            len_q      <= len_d;
            bit_cnt_q  <= bit_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            w          <= w_d;
            w_valid    <= w_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule
